// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants and receiver state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int unsigned c_DEF_CLKS_PER_BIT = 16;
    localparam int unsigned c_DEF_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_rx_state_e;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_sync2.sv
// ============================================================================
// Module      : uart_sync2
// Description : Two-flop synchronizer for an idle-high serial net.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_sync2 (
    input  logic clk_sis,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Resetting to 1 keeps an idle line from looking like a start bit.
    always_ff @(posedge clk_sis) begin
        if (!rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : uart_sync2

`default_nettype wire

// File: rtl/uart_rx_deser.sv
// ============================================================================
// Module      : uart_rx_deser
// Description : Oversampling UART receiver; LSB-first bytes with valid/error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = c_DEF_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = c_DEF_DATA_BITS
) (
    input  logic                 clk_sis,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned c_IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_M1 = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_BITS - 1);

    logic                 w_rx_s;
    logic [DATA_BITS:0]   w_shift_ext;
    logic [DATA_BITS-1:0] w_shift_next;

    uart_rx_state_e       r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_IDX_W-1:0]   r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_stop_seen;
    logic                 r_stop_bit;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_busy;

    uart_sync2 u_sync (
        .clk_sis (clk_sis),
        .rst     (rst),
        .i_d     (rx),
        .o_q     (w_rx_s)
    );

    // New bit enters at the MSB so the first received bit ends up at bit 0.
    assign w_shift_ext  = {w_rx_s, r_shift};
    assign w_shift_next = w_shift_ext[DATA_BITS:1];

    always_ff @(posedge clk_sis) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_stop_seen <= 1'b0;
            r_stop_bit  <= 1'b0;
            r_data_out  <= '0;
            r_valid     <= 1'b0;
            r_ferr      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= ST_START;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (r_cnt == c_HALF_M1) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state   <= ST_DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == c_FULL_M1) begin
                        r_cnt     <= '0;
                        r_shift   <= w_shift_next;
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == c_LAST_IDX) begin
                            r_state <= ST_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    // The stop sample is held one cycle so the result lands on the following edge.
                    if (r_stop_seen) begin
                        r_stop_seen <= 1'b0;
                        r_cnt       <= '0;
                        if (r_stop_bit) begin
                            r_data_out <= r_shift;
                            r_valid    <= 1'b1;
                            r_state    <= ST_IDLE;
                            r_busy     <= 1'b0;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= ST_BREAK;
                        end
                    end else if (r_cnt == c_FULL_M1) begin
                        r_stop_seen <= 1'b1;
                        r_stop_bit  <= w_rx_s;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_valid;
    assign frame_err  = r_ferr;
    assign busy       = r_busy;

endmodule : uart_rx_deser

`default_nettype wire

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
- Receive-side deserializer that consumes the serial line driven by a UART transmitter (tx1/tx2 nets) and recovers bytes.
- Oversamples rx on clk_sis using an internal bit-period counter, validates start/stop bits, and emits parallel data with a one-cycle valid pulse.
- Sits directly downstream of the UART transmit stage.
- Feeds the received-byte consumer (FIFO/register file) in each UART instance.

Parameters:
- CLKS_PER_BIT, 16, clk_sis cycles per serial bit; must be even and ≥4.
- DATA_BITS, 8, payload bits per frame, LSB first.

Ports:
- clk_sis  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-low reset.
- rx  input  1  serial line; idles high.
- data_out  output  DATA_BITS  last correctly framed byte; held until next valid frame.
- data_valid  output  1  one-cycle pulse; data_out updated in the same cycle.
- frame_err  output  1  one-cycle pulse when the stop bit samples low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset is sampled on clk_sis rising edge only; rst==0 forces the following, regardless of state:
  - data_out=0, data_valid=0, frame_err=0, busy=0.
  - FSM=IDLE; counters and shift register = 0.
  - Synchronizer flops = 1.
- Synchronizer:
  - rx passes through 2 flops; rx_s is the second stage.
  - All FSM decisions use rx_s only.
- Counters:
  - cnt is a bit-period counter of width clog2(CLKS_PER_BIT).
  - bit_idx is a counter of width clog2(DATA_BITS+1).
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - On the edge where rx_s==0, go to START with cnt=0. Call this edge D.
- START:
  - cnt increments each cycle.
  - At cnt==CLKS_PER_BIT/2-1, sample rx_s (sample time D+CLKS_PER_BIT/2).
  - If rx_s==0: go to DATA, cnt=0, bit_idx=0.
  - If rx_s==1: glitch; go to IDLE with no output pulse.
- DATA:
  - At cnt==CLKS_PER_BIT-1, sample rx_s and shift it into the MSB of a right-shift register (LSB-first reception). Reset cnt and increment bit_idx.
  - After the DATA_BITS-th sample, go to STOP with cnt=0.
  - Bit i (0-based) is sampled at D+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT.
- STOP:
  - At cnt==CLKS_PER_BIT-1, sample rx_s.
  - If rx_s==1: next edge loads data_out with the shift register, pulses data_valid for 1 cycle, and sets FSM=IDLE.
  - If rx_s==0: next edge pulses frame_err for 1 cycle, leaves data_out unchanged, and sets FSM=BREAK.
- BREAK:
  - Stay until rx_s==1, then go to IDLE.
  - A held-low line produces exactly one frame_err, never repeated frames.
- Latency:
  - data_valid rises at edge D+CLKS_PER_BIT/2+(DATA_BITS+1)*CLKS_PER_BIT+1.
  - With defaults: D+153.
- Back-to-back frames:
  - Returning to IDLE right after the stop mid-sample allows a start edge half a bit later to be detected; no frames are dropped at the nominal rate.
- busy:
  - Registered; equals (next state != IDLE).
  - Low during the data_valid cycle.
- Simultaneous events:
  - data_valid and frame_err are never high together.
  - rst==0 overrides any pending pulse.
- Reset mid-frame discards the partial byte; no pulse is emitted afterward.

Decomposition:
- Package uart_pkg holds:
  - State encoding enum (IDLE=0, START=1, DATA=2, STOP=3, BREAK=4).
  - Default CLKS_PER_BIT and DATA_BITS constants, shared with the transmitter.
- One sub-module, uart_sync2:
  - Parameterless 2-flop synchronizer.
  - Synchronous active-low reset to 1.
  - Reusable wherever the UARTs cross the serial net.

Test Plan:
- Send frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1 LSB first, stop 1) at 16 clk/bit → data_valid one cycle at D+153, data_out=0xA5, frame_err=0, busy low afterward.
- Drive rx low for 5 cycles then high (glitch < half bit) → FSM returns to IDLE, no data_valid, no frame_err, data_out unchanged.
- Send 0x3C with stop bit 0, then hold rx low 40 cycles → single frame_err pulse, data_out keeps previous 0xA5, busy high until rx_s returns 1.
- Three back-to-back frames 0x00, 0xFF, 0x81 with no idle gap → three data_valid pulses spaced 160 cycles apart with correct values in order.
- Assert rst=0 for 1 cycle in the middle of bit 4 of frame 0x55, then send 0x12 → no output for 0x55, all outputs 0 after reset, 0x12 received correctly.
- Re-run the 0xA5 case with CLKS_PER_BIT=4 → data_valid at D+39, data_out=0xA5.
